sys_clk_timer_master: RTL



---
 rtl/sys_clk_timer_master_if.sv | 20 ++
 rtl/sys_clk_timer_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sys_clk_timer_master_if.sv
// Avalon-MM link between the timer master and the interval timer s1 port,
// including the timer's level interrupt.
interface sys_clk_timer_master_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_readdata, tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_readdata, tmr_irq
  );
endinterface

// File: rtl/sys_clk_timer_master.sv
// Autonomous driver for the interval timer: starts/stops it, clears each
// timeout, counts serviced ticks and reads back counter snapshots.
module sys_clk_timer_master #(
  parameter int          TICK_WIDTH = 32,
  parameter logic [15:0] CTRL_RUN   = 16'h0007,
  parameter logic [15:0] CTRL_STOP  = 16'h0008
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      snap_req,
  sys_clk_timer_master_if.master    tmr,
  output logic                      running,
  output logic                      tick,
  output logic [TICK_WIDTH-1:0]     tick_count,
  output logic                      snap_busy,
  output logic                      snap_valid,
  output logic [31:0]               snap_value
);

  typedef enum logic [3:0] {
    IDLE, START_WR, RUN, CLR_WR, STOP_WR,
    SNAP_WR, SNAP_RDL, SNAP_CAPL, SNAP_RDH, SNAP_CAPH
  } state_t;

  state_t                state_q;
  logic [2:0]            addr_q;
  logic                  cs_q;
  logic                  wn_q;
  logic [15:0]           wdata_q;
  logic                  running_q;
  logic                  tick_q;
  logic [TICK_WIDTH-1:0] count_q;
  logic [TICK_WIDTH-1:0] count_d;
  logic                  busy_q;
  logic                  valid_q;
  logic [31:0]           snap_q;

  assign count_d = count_q + TICK_WIDTH'(1);

  // Sequencer: every bus output is registered and is set on the edge that
  // enters the state performing the transfer, so each transfer lasts exactly
  // the one cycle spent in that state. busy_q doubles as the pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 3'd0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      wdata_q   <= 16'h0000;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      snap_q    <= 32'h0;
    end else begin
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      tick_q  <= 1'b0;
      valid_q <= 1'b0;
      if (snap_req && !busy_q) busy_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= START_WR;
            cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd1; wdata_q <= CTRL_RUN;
            running_q <= 1'b1;
          end else if (busy_q) begin
            state_q <= SNAP_WR;
            cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd4; wdata_q <= 16'h0000;
          end
        end
        START_WR: state_q <= RUN;
        RUN: begin
          if (tmr.tmr_irq) begin
            state_q <= CLR_WR;
            cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd0; wdata_q <= 16'h0000;
            tick_q  <= 1'b1;
            count_q <= count_d;
          end else if (!enable) begin
            state_q <= STOP_WR;
            cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd1; wdata_q <= CTRL_STOP;
            running_q <= 1'b0;
          end else if (busy_q) begin
            state_q <= SNAP_WR;
            cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd4; wdata_q <= 16'h0000;
          end
        end
        CLR_WR:  state_q <= RUN;
        STOP_WR: state_q <= IDLE;
        SNAP_WR: begin
          state_q <= SNAP_RDL;
          cs_q <= 1'b1; addr_q <= 3'd4;
        end
        SNAP_RDL: state_q <= SNAP_CAPL;
        SNAP_CAPL: begin
          snap_q[15:0] <= tmr.tmr_readdata;
          state_q <= SNAP_RDH;
          cs_q <= 1'b1; addr_q <= 3'd5;
        end
        SNAP_RDH: state_q <= SNAP_CAPH;
        SNAP_CAPH: begin
          snap_q[31:16] <= tmr.tmr_readdata;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= running_q ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tmr.tmr_address    = addr_q;
  assign tmr.tmr_chipselect = cs_q;
  assign tmr.tmr_write_n    = wn_q;
  assign tmr.tmr_writedata  = wdata_q;
  assign running            = running_q;
  assign tick               = tick_q;
  assign tick_count         = count_q;
  assign snap_busy          = busy_q;
  assign snap_valid         = valid_q;
  assign snap_value         = snap_q;

endmodule
